// File: rtl/wb_commit_checker.sv
// Writeback self-check: compares committed wb_data against a table of expected
// results indexed by commit PC, and reports pass/fail counts, the first mismatch and a stall timeout.
module wb_commit_checker #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int PC_BASE   = 16,
  parameter int PC_STRIDE = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   i_cfg_idx,
  input  logic [DATA_W-1:0]          i_cfg_data,
  input  logic                       i_cfg_en,
  input  logic                       i_start,
  input  logic                       i_commit_valid,
  input  logic [DATA_W-1:0]          i_pc_debug,
  input  logic [DATA_W-1:0]          i_wb_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_pass,
  output logic                       o_timeout,
  output logic [$clog2(DEPTH+1)-1:0] o_pass_cnt,
  output logic [$clog2(DEPTH+1)-1:0] o_fail_cnt,
  output logic [$clog2(DEPTH)-1:0]   o_first_fail_idx,
  output logic [DATA_W-1:0]          o_first_fail_data
);

  // state     | meaning
  // S_IDLE    | after reset, table may be loaded
  // S_RUN     | checking commits, table locked
  // S_DONE    | every enabled entry checked
  // S_TIMEOUT | no counted check for TIMEOUT cycles
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int SHIFT = $clog2(PC_STRIDE);
  localparam logic [DATA_W-1:0] BASE_L   = DATA_W'(PC_BASE);
  localparam logic [DATA_W-1:0] MASK_L   = DATA_W'(PC_STRIDE - 1);
  localparam logic [DATA_W-1:0] DEPTH_L  = DATA_W'(DEPTH);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    en_q, en_d;
  logic [DEPTH-1:0]    chk_q, chk_d;
  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]    ff_idx_q, ff_idx_d;
  logic [DATA_W-1:0]   ff_data_q, ff_data_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   exp_q [DEPTH];

  logic [DATA_W-1:0]   pc_off;
  logic [DATA_W-1:0]   pc_slot;
  logic [IDX_W-1:0]    hit_idx;
  logic                hit;
  logic                cfg_wr;
  logic                count_ok;
  logic                match;

  // Unsigned subtract wraps for pc < PC_BASE; the explicit >= test rejects those.
  assign pc_off   = i_pc_debug - BASE_L;
  assign pc_slot  = pc_off >> SHIFT;
  assign hit      = i_commit_valid && (i_pc_debug >= BASE_L) &&
                    ((pc_off & MASK_L) == '0) && (pc_slot < DEPTH_L);
  assign hit_idx  = pc_slot[IDX_W-1:0];
  assign cfg_wr   = i_cfg_we && (state_q != S_RUN);
  assign count_ok = (state_q == S_RUN) && hit && en_q[hit_idx] && !chk_q[hit_idx];
  assign match    = (i_wb_data == exp_q[hit_idx]);

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    chk_d      = chk_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_idx_d   = ff_idx_q;
    ff_data_d  = ff_data_q;
    timer_d    = timer_q;

    if (cfg_wr) begin
      en_d[i_cfg_idx] = i_cfg_en;
    end

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        // Start looks at en_d so a same-cycle table write is already visible.
        if (i_start) begin
          chk_d      = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          ff_idx_d   = '0;
          ff_data_d  = '0;
          timer_d    = '0;
          state_d    = (|en_d) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (count_ok) begin
          chk_d[hit_idx] = 1'b1;
          timer_d        = '0;
          if (match) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end else begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
            if (fail_cnt_q == '0) begin
              ff_idx_d  = hit_idx;
              ff_data_d = i_wb_data;
            end
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
        // Completion wins over timeout when the last check lands on the limit.
        if ((en_q & ~chk_d) == '0) begin
          state_d = S_DONE;
        end else if (!count_ok && (timer_q == TMR_LAST)) begin
          state_d = S_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      en_q       <= '0;
      chk_q      <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_data_q  <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      chk_q      <= chk_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_idx_q   <= ff_idx_d;
      ff_data_q  <= ff_data_d;
      timer_q    <= timer_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (cfg_wr) begin
      exp_q[i_cfg_idx] <= i_cfg_data;
    end
  end

  assign o_busy            = (state_q == S_RUN);
  assign o_done            = (state_q == S_DONE) || (state_q == S_TIMEOUT);
  assign o_timeout         = (state_q == S_TIMEOUT);
  assign o_pass            = (state_q == S_DONE) && (fail_cnt_q == '0);
  assign o_pass_cnt        = pass_cnt_q;
  assign o_fail_cnt        = fail_cnt_q;
  assign o_first_fail_idx  = ff_idx_q;
  assign o_first_fail_data = ff_data_q;

endmodule

// File: tb/tb_wb_commit_checker.sv
// Directed and random checks of wb_commit_checker against a cycle-stepped
// reference model that applies the table rules with plain arithmetic.
module tb_wb_commit_checker;
  localparam int DEPTH  = 8;
  localparam int BASE   = 16;
  localparam int STRIDE = 4;
  localparam int TMO    = 8;

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TO = 3;

  logic        clk = 1'b0;
  logic        rst, cfg_we, cfg_en, start, cv;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_data, pc, wbd;
  logic        busy, done, pass, tmo;
  logic [3:0]  pcnt, fcnt;
  logic [2:0]  ffi;
  logic [31:0] ffd;

  int total = 0;
  int bad   = 0;

  int          m_state, m_pass, m_fail, m_ffi, m_idle;
  logic [31:0] m_ffd;
  logic [31:0] m_exp [DEPTH];
  bit          m_en  [DEPTH];
  bit          m_chk [DEPTH];

  wb_commit_checker #(
    .DATA_W(32), .DEPTH(DEPTH), .PC_BASE(BASE), .PC_STRIDE(STRIDE), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx),
    .i_cfg_data(cfg_data), .i_cfg_en(cfg_en), .i_start(start),
    .i_commit_valid(cv), .i_pc_debug(pc), .i_wb_data(wbd),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo),
    .o_pass_cnt(pcnt), .o_fail_cnt(fcnt), .o_first_fail_idx(ffi),
    .o_first_fail_data(ffd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_chk[i] = 0;
    m_pass = 0; m_fail = 0; m_ffi = 0; m_ffd = '0; m_idle = 0;
  endfunction

  function automatic void model_edge();
    longint p;
    int     k;
    bit     counted, any, all;
    if (rst) begin
      m_state = M_IDLE;
      for (int i = 0; i < DEPTH; i++) m_en[i] = 0;
      model_clear();
      return;
    end
    if (m_state != M_RUN) begin
      if (cfg_we) begin
        m_exp[cfg_idx] = cfg_data;
        m_en[cfg_idx]  = cfg_en;
      end
      if (start) begin
        model_clear();
        any = 0;
        for (int i = 0; i < DEPTH; i++) any |= m_en[i];
        m_state = any ? M_RUN : M_DONE;
      end
    end else begin
      counted = 0;
      p = longint'(pc);
      if (cv && p >= BASE && (p - BASE) % STRIDE == 0 && (p - BASE) / STRIDE < DEPTH) begin
        k = int'((p - BASE) / STRIDE);
        if (m_en[k] && !m_chk[k]) begin
          counted  = 1;
          m_chk[k] = 1;
          if (wbd == m_exp[k]) m_pass++;
          else begin
            if (m_fail == 0) begin m_ffi = k; m_ffd = wbd; end
            m_fail++;
          end
        end
      end
      m_idle = counted ? 0 : m_idle + 1;
      all = 1;
      for (int i = 0; i < DEPTH; i++) if (m_en[i] && !m_chk[i]) all = 0;
      if (all) m_state = M_DONE;
      else if (m_idle >= TMO) m_state = M_TO;
    end
  endfunction

  task automatic compare_all();
    chk("busy",      busy, m_state == M_RUN);
    chk("done",      done, m_state == M_DONE || m_state == M_TO);
    chk("timeout",   tmo,  m_state == M_TO);
    chk("pass",      pass, m_state == M_DONE && m_fail == 0);
    chk("pass_cnt",  pcnt, m_pass);
    chk("fail_cnt",  fcnt, m_fail);
    chk("ff_idx",    ffi,  m_ffi);
    chk("ff_data",   ffd,  m_ffd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic cfg(input int i, input logic [31:0] d, input bit e);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_data = d; cfg_en = e;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic commit(input logic [31:0] p, input logic [31:0] d);
    cv = 1'b1; pc = p; wbd = d;
    tick();
    cv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_en = 0; start = 0; cv = 0;
    cfg_idx = '0; cfg_data = '0; pc = '0; wbd = '0;
    for (int i = 0; i < DEPTH; i++) m_exp[i] = '0;
    m_state = M_IDLE;
    model_clear();
    do_reset();
    chk("rst_done", done, 0);
    chk("rst_pcnt", pcnt, 0);

    // Start with an empty table finishes at once with a pass.
    do_start();
    chk("empty_pass", pass, 1);

    // T1
    do_reset();
    cfg(0, 32'h23, 1); cfg(1, 32'h23, 1); cfg(2, 32'h0, 1);
    do_start();
    commit(16, 32'h23); commit(20, 32'h23);
    chk("t1_not_done", done, 0);
    commit(24, 32'h0);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_pcnt", pcnt, 3);

    // T2: restart from DONE keeps the table
    do_start();
    commit(16, 32'h23); commit(20, 32'h24); commit(24, 32'h0);
    chk("t2_fcnt", fcnt, 1);
    chk("t2_ffi", ffi, 1);
    chk("t2_ffd", ffd, 32'h24);
    chk("t2_pass", pass, 0);

    // T3: misses and invalid cycles
    do_start();
    commit(12, 32'h23); commit(18, 32'h23); commit(16 + 4 * DEPTH, 32'h23);
    pc = 16; wbd = 32'h23; tick();
    chk("t3_pcnt", pcnt, 0);
    chk("t3_fcnt", fcnt, 0);
    chk("t3_busy", busy, 1);
    commit(16, 32'h23); commit(20, 32'h23); commit(24, 32'h0);

    // T4: replay of a checked pc is ignored
    do_start();
    commit(16, 32'h23); commit(16, 32'h99);
    chk("t4_pcnt", pcnt, 1);
    chk("t4_fcnt", fcnt, 0);
    commit(20, 32'h23); commit(24, 32'h0);

    // T5: timeout after TMO cycles without a counted check
    do_reset();
    cfg(0, 32'h10, 1); cfg(1, 32'h11, 1);
    do_start();
    commit(16, 32'h10);
    repeat (TMO - 1) tick();
    chk("t5_no_to", tmo, 0);
    tick();
    chk("t5_to", tmo, 1);
    chk("t5_nopass", pass, 0);

    // T6: reset aborts RUN; RUN writes ignored; same-cycle write+start
    do_reset();
    cfg(0, 32'h55, 1);
    do_start();
    tick(); tick();
    do_reset();
    chk("t6_abort", busy, 0);
    cfg(0, 32'h55, 1); cfg(1, 32'h66, 1);
    do_start();
    cfg(0, 32'h77, 1);
    commit(16, 32'h55); commit(20, 32'h66);
    chk("t6_pcnt", pcnt, 2);
    chk("t6_pass", pass, 1);
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_data = 32'h33; cfg_en = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("t6_clr", pcnt, 0);
    chk("t6_busy", busy, 1);
    commit(16, 32'h55); commit(20, 32'h66);
    chk("t6_wait", busy, 1);
    commit(24, 32'h33);
    chk("t6_pass3", pcnt, 3);

    // Random rounds, each restarting from DONE/TIMEOUT
    do_reset();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < DEPTH; k++) cfg(k, 32'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      do_start();
      for (int c = 0; c < 60 && m_state == M_RUN; c++) begin
        cv  = $urandom_range(0, 9) < 8;
        pc  = ($urandom_range(0, 9) < 8) ? 32'(BASE + STRIDE * $urandom_range(0, DEPTH - 1))
                                         : 32'($urandom_range(0, 60));
        wbd = 32'($urandom_range(0, 3));
        tick();
      end
      cv = 1'b0;
      repeat (TMO + 1) tick();
      chk("rnd_ended", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
